// File: rtl/apb_periph_arbiter.sv
// Two-port round-robin APB arbiter in front of the peripheral bus wrapper.
// One transfer in flight; an optional ACCESS-phase timeout aborts hung slaves with PSLVERR.
module apb_periph_arbiter #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     rq_psel_i,
    input  logic [1:0]                     rq_penable_i,
    input  logic [1:0]                     rq_pwrite_i,
    input  logic [1:0][APB_ADDR_WIDTH-1:0] rq_paddr_i,
    input  logic [1:0][APB_DATA_WIDTH-1:0] rq_pwdata_i,
    output logic [1:0]                     rq_pready_o,
    output logic [APB_DATA_WIDTH-1:0]      rq_prdata_o,
    output logic [1:0]                     rq_pslverr_o,
    output logic                           m_psel_o,
    output logic                           m_penable_o,
    output logic                           m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]      m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]      m_pwdata_o,
    input  logic                           m_pready_i,
    input  logic [APB_DATA_WIDTH-1:0]      m_prdata_i,
    input  logic                           m_pslverr_i,
    output logic                           timeout_o,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    logic                      latch_en;
    logic                      pwrite_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      timeout_hit;

    // PENABLE from the requesters carries no information for arbitration.
    logic unused_penable;
    assign unused_penable = ^rq_penable_i;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // Transfer payload is only observed while SETUP/ACCESS, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (latch_en) begin
            pwrite_q <= rq_pwrite_i[grant_d];
            paddr_q  <= rq_paddr_i[grant_d];
            pwdata_q <= rq_pwdata_i[grant_d];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        latch_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|rq_psel_i) begin
                    grant_d  = (&rq_psel_i) ? ~last_grant_q : rq_psel_i[1];
                    latch_en = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (m_pready_i || timeout_hit) begin
                    last_grant_d = grant_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_psel_o     = 1'b0;
        m_penable_o  = 1'b0;
        m_pwrite_o   = 1'b0;
        m_paddr_o    = '0;
        m_pwdata_o   = '0;
        rq_pready_o  = 2'b00;
        rq_prdata_o  = '0;
        rq_pslverr_o = 2'b00;
        timeout_o    = 1'b0;
        busy_o       = (state_q != IDLE);
        if (state_q == SETUP || state_q == ACCESS) begin
            m_psel_o   = 1'b1;
            m_pwrite_o = pwrite_q;
            m_paddr_o  = paddr_q;
            m_pwdata_o = pwdata_q;
        end
        if (state_q == ACCESS) begin
            m_penable_o = 1'b1;
            if (m_pready_i) begin
                rq_pready_o[grant_q]  = 1'b1;
                rq_prdata_o           = m_prdata_i;
                rq_pslverr_o[grant_q] = m_pslverr_i;
            end else if (timeout_hit) begin
                rq_pready_o[grant_q]  = 1'b1;
                rq_pslverr_o[grant_q] = 1'b1;
                timeout_o             = 1'b1;
            end
        end
    end

endmodule

// File: doc/apb_periph_arbiter.md
Name: apb_periph_arbiter

Overview:
- Two-requester APB arbiter that shares the single peripheral APB bus between the core data-side bridge (port 0) and the debug/SPI-slave bridge (port 1).
- Its downstream master port drives the slave port of the peripheral bus wrapper, which decodes the address onto UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC-ctrl, monitor and debug.
- Round-robin grant, one transfer in flight at a time.
- Programmable access timeout so that a hung peripheral cannot lock the bus.

Parameters:
- APB_ADDR_WIDTH, 32, address width on all ports.
- APB_DATA_WIDTH, 32, data width on all ports.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- rq_psel_i  in  2  per-requester PSEL (bit n = port n).
- rq_penable_i  in  2  per-requester PENABLE.
- rq_pwrite_i  in  2  per-requester PWRITE.
- rq_paddr_i  in  2xAPB_ADDR_WIDTH  per-requester PADDR.
- rq_pwdata_i  in  2xAPB_DATA_WIDTH  per-requester PWDATA.
- rq_pready_o  out  2  per-requester PREADY.
- rq_prdata_o  out  APB_DATA_WIDTH  read data, shared; valid only with the matching rq_pready_o bit.
- rq_pslverr_o  out  2  per-requester PSLVERR.
- m_psel_o  out  1  downstream PSEL.
- m_penable_o  out  1  downstream PENABLE.
- m_pwrite_o  out  1  downstream PWRITE.
- m_paddr_o  out  APB_ADDR_WIDTH  downstream PADDR.
- m_pwdata_o  out  APB_DATA_WIDTH  downstream PWDATA.
- m_pready_i  in  1  downstream PREADY.
- m_prdata_i  in  APB_DATA_WIDTH  downstream PRDATA.
- m_pslverr_i  in  1  downstream PSLVERR.
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, DONE.
- Reset (rst_i high at a clock edge):
  - state goes to IDLE, last_grant = 1 (port 0 wins first), timeout counter = 0.
  - All outputs are 0: m_*, rq_pready_o, rq_prdata_o, rq_pslverr_o, timeout_o, busy_o.
  - Reset mid-transfer aborts the transfer silently, with no response to the requester.
- IDLE:
  - A request is rq_psel_i[n] = 1; rq_penable_i is ignored for arbitration.
  - If both ports request, grant the port that is not last_grant. If only one requests, grant it.
  - On any grant, latch the granted port's pwrite, paddr and pwdata into registers, store grant, and go to SETUP.
- SETUP (1 cycle): m_psel_o = 1, m_penable_o = 0, address/data/write from the latched registers. Then go to ACCESS.
- ACCESS:
  - m_psel_o = 1, m_penable_o = 1, and the counter increments every cycle.
  - If m_pready_i = 1: rq_pready_o[grant] = 1, rq_prdata_o = m_prdata_i, rq_pslverr_o[grant] = m_pslverr_i (all combinational in this cycle). Set last_grant = grant and go to DONE.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1:
    - rq_pready_o[grant] = 1, rq_pslverr_o[grant] = 1, rq_prdata_o = 0, timeout_o = 1.
    - Set last_grant = grant and go to DONE.
    - A late m_pready_i after an abort is ignored.
- DONE (1 cycle):
  - All m_* signals are 0 and the counter is cleared. Go to IDLE.
  - This gives the requester one cycle to drop or change PSEL before re-arbitration, so no stale request is double-served.
- The non-granted port always sees rq_pready_o = 0 and stalls; its request is held and served next.
- Latency: request seen in IDLE at cycle T → SETUP at T+1 → earliest completion (rq_pready_o) at T+2.
  - Back-to-back transfers from one port: 4 cycles each.
  - With both ports continuously requesting, grants strictly alternate.
- A requester dropping rq_psel_i after grant does not cancel the downstream transfer; it still completes and the response is discarded.
- m_paddr_o, m_pwdata_o and m_pwrite_o hold their latched values through SETUP and ACCESS; they are 0 in IDLE and DONE.

Test Plan:
- Single port-0 read, addr 0x1A10_1000, peripheral returns 0xDEADBEEF with pready at first ACCESS cycle → m_psel_o at T+1, m_penable_o at T+2, rq_pready_o = 2'b01 and rq_prdata_o = 0xDEADBEEF at T+2, pslverr = 0.
- Both ports request in the same cycle from reset → port 0 granted first. Port 1 (write 0x5 to 0x1A10_0000) appears on m_* 4 cycles later. Repeat the pair → grant order 0,1,0,1.
- Peripheral inserts 3 wait states → rq_pready_o stays 0 for 3 ACCESS cycles and asserts in the 4th; m_paddr_o is stable throughout.
- TIMEOUT_CYCLES = 8, m_pready_i tied 0 → after 8 ACCESS cycles: rq_pready_o[grant] = 1, rq_pslverr_o[grant] = 1, rq_prdata_o = 0, timeout_o single pulse. Next request is served normally.
- m_pslverr_i = 1 on a port-1 write → rq_pslverr_o = 2'b10 coincident with pready, timeout_o = 0.
- rst_i asserted in the ACCESS cycle → next cycle all outputs 0 and busy_o = 0. Following simultaneous requests grant port 0.
